conv2d_patch_loader: RTL and testbench

//  Upstream feeder for the conv2D patch FIFO. Walks the output grid of a KxK

---
 rtl/conv2d_patch_loader_if.sv | 33 +++
 rtl/conv2d_patch_loader.sv | 194 +++++++++++++++++++
 tb/tb_conv2d_patch_loader.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_patch_loader_if.sv
// ---------------------------------------------------------------------------
// conv2d_patch_loader_if
// Bundles the patch loader's two buses:
//   - feature-map memory read port: mem_rd_en, mem_addr (loader drives),
//     mem_data (memory drives, valid one cycle after mem_rd_en)
//   - patch FIFO side: wr_en, data_in, rd_en (loader drives),
//     patch_ack (downstream MAC array drives)
// Modports:
//   master - the patch loader
//   slave  - the memory / FIFO / MAC environment
// ---------------------------------------------------------------------------
interface conv2d_patch_loader_if #(
    parameter int DATA_Width = 14,
    parameter int ADDR_W     = 16
);
    logic                  mem_rd_en;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_Width-1:0] mem_data;
    logic                  wr_en;
    logic [DATA_Width-1:0] data_in;
    logic                  rd_en;
    logic                  patch_ack;

    modport master (
        output mem_rd_en, mem_addr, wr_en, data_in, rd_en,
        input  mem_data, patch_ack
    );

    modport slave (
        input  mem_rd_en, mem_addr, wr_en, data_in, rd_en,
        output mem_data, patch_ack
    );
endinterface

// File: rtl/conv2d_patch_loader.sv
// ---------------------------------------------------------------------------
// conv2d_patch_loader
// Walks the output grid of a KxK convolution, fetches each receptive-field
// patch (kr, kc outer, channel innermost) from feature-map memory and streams
// it one element per cycle into the patch FIFO. After the last element it
// pulses rd_en so the FIFO latches the flattened patch, then waits for
// patch_ack before loading the next one. done pulses after the last ack.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   start         begin one layer pass (only sampled while idle)
//   bus           conv2d_patch_loader_if.master (memory + FIFO + ack)
//   out_row/col   output-grid coordinate of the current patch
//   busy          high whenever not idle
//   done          one-cycle pulse after the last patch is acknowledged
//
// Build option: define CONV_LOADER_PAD_EN to honour PAD (border slots become
// zero-filled pad slots with no memory read). Without it the layer is a
// valid (unpadded) convolution and every slot issues a read.
// ---------------------------------------------------------------------------
module conv2d_patch_loader #(
    parameter int DATA_Width = 14,
    parameter int IMG_H      = 8,
    parameter int IMG_W      = 8,
    parameter int CH         = 3,
    parameter int K          = 3,
    parameter int STRIDE     = 2,
    parameter int PAD        = 1,
    parameter int ADDR_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    conv2d_patch_loader_if.master        bus,
    output logic [7:0]                   out_row,
    output logic [7:0]                   out_col,
    output logic                         busy,
    output logic                         done
);

`ifdef CONV_LOADER_PAD_EN
    localparam int PadEff = PAD;
`else
    // Padding disabled: PAD stays in the parameter list so instances need no edits.
    localparam int PadEff = PAD - PAD;
`endif

    localparam int Patch = K * K * CH;
    localparam int OutH  = (IMG_H + 2 * PadEff - K) / STRIDE + 1;
    localparam int OutW  = (IMG_W + 2 * PadEff - K) / STRIDE + 1;
    localparam int KW    = (K > 1) ? $clog2(K) : 1;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int SW    = $clog2(Patch + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StEmit,
        StWait,
        StDone
    } state_e;

    state_e          state_q;
    logic [KW-1:0]   kr_q;
    logic [KW-1:0]   kc_q;
    logic [CW-1:0]   ch_q;
    logic [SW-1:0]   slot_q;
    logic [7:0]      row_q;
    logic [7:0]      col_q;
    logic            wr_en_q;
    logic            pad_q;
    logic            rd_en_q;
    logic            busy_q;
    logic            done_q;

    int              ir;
    int              ic;
    logic            in_range;
    logic            issue;
    logic            last_patch;

    // Issue stage: the slot counters name the slot being issued this cycle,
    // so the read address is decoded straight from them.
    always_comb begin
        ir         = int'(row_q) * STRIDE + int'(kr_q) - PadEff;
        ic         = int'(col_q) * STRIDE + int'(kc_q) - PadEff;
        in_range   = (ir >= 0) && (ir < IMG_H) && (ic >= 0) && (ic < IMG_W);
        issue      = (state_q == StLoad) && in_range;
        last_patch = (row_q == 8'(OutH - 1)) && (col_q == 8'(OutW - 1));
    end

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = issue ? ADDR_W'((ir * IMG_W + ic) * CH + int'(ch_q)) : '0;

    // Write stage: wr_en_q/pad_q are the issue tags delayed one cycle so they
    // line up with mem_data.
    assign bus.wr_en   = wr_en_q;
    assign bus.data_in = (wr_en_q && !pad_q) ? bus.mem_data : DATA_Width'(0);
    assign bus.rd_en   = rd_en_q;

    assign out_row = row_q;
    assign out_col = col_q;
    assign busy    = busy_q;
    assign done    = done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            kr_q    <= '0;
            kc_q    <= '0;
            ch_q    <= '0;
            slot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wr_en_q <= 1'b0;
            pad_q   <= 1'b0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            pad_q   <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    wr_en_q <= 1'b1;
                    pad_q   <= !in_range;
                    if (ch_q == CW'(CH - 1)) begin
                        ch_q <= '0;
                        if (kc_q == KW'(K - 1)) begin
                            kc_q <= '0;
                            kr_q <= kr_q + 1'b1;
                        end else begin
                            kc_q <= kc_q + 1'b1;
                        end
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                    // Last slot: clear the walk so the next patch starts at slot 0.
                    if (slot_q == SW'(Patch - 1)) begin
                        slot_q  <= '0;
                        kr_q    <= '0;
                        kc_q    <= '0;
                        ch_q    <= '0;
                        state_q <= StFlush;
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                StFlush: begin
                    rd_en_q <= 1'b1;
                    state_q <= StEmit;
                end
                StEmit: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (bus.patch_ack) begin
                        if (last_patch) begin
                            row_q   <= '0;
                            col_q   <= '0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            if (col_q == 8'(OutW - 1)) begin
                                col_q <= '0;
                                row_q <= row_q + 8'd1;
                            end else begin
                                col_q <= col_q + 8'd1;
                            end
                            state_q <= StLoad;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_patch_loader.sv
// ---------------------------------------------------------------------------
// tb_conv2d_patch_loader
// Bench for conv2d_patch_loader. Memory model returns mem_addr[13:0] one
// cycle after mem_rd_en. Expected FIFO words for a whole pass are queued when
// start is driven and popped on every wr_en. The first patch is also checked
// against a literal table. Honours CONV_LOADER_PAD_EN like the design.
// ---------------------------------------------------------------------------
module tb_conv2d_patch_loader;

    localparam int DW     = 14;
    localparam int IMG_H  = 8;
    localparam int IMG_W  = 8;
    localparam int CH     = 3;
    localparam int K      = 3;
    localparam int STRIDE = 2;
    localparam int PAD    = 1;
    localparam int ADDR_W = 16;
`ifdef CONV_LOADER_PAD_EN
    localparam int PAD_EFF = PAD;
`else
    localparam int PAD_EFF = 0;
`endif
    localparam int PATCH = K * K * CH;
    localparam int OUT_H = (IMG_H + 2 * PAD_EFF - K) / STRIDE + 1;
    localparam int OUT_W = (IMG_W + 2 * PAD_EFF - K) / STRIDE + 1;
    localparam int NP    = OUT_H * OUT_W;

    typedef struct packed {
        int first;
        int len;
        int pad;
        int base;
    } seg_t;

    typedef struct packed {
        int slot;
        int exp_data;
    } vec_t;

`ifdef CONV_LOADER_PAD_EN
    localparam int NSEG = 4;
    seg_t segs [NSEG] = '{'{0, 12, 1, 0}, '{12, 6, 0, 0}, '{18, 3, 1, 0}, '{21, 6, 0, 24}};
`else
    localparam int NSEG = 3;
    seg_t segs [NSEG] = '{'{0, 9, 0, 0}, '{9, 9, 0, 24}, '{18, 9, 0, 48}};
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] out_row;
    logic [7:0] out_col;
    logic       busy;
    logic       done;

    conv2d_patch_loader_if #(.DATA_Width(DW), .ADDR_W(ADDR_W)) bus ();

    conv2d_patch_loader #(
        .DATA_Width(DW), .IMG_H(IMG_H), .IMG_W(IMG_W), .CH(CH), .K(K),
        .STRIDE(STRIDE), .PAD(PAD), .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .out_row (out_row),
        .out_col (out_col),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Memory: data is the low 14 address bits; junk when no read was issued.
    always @(posedge clk) bus.mem_data <= bus.mem_rd_en ? bus.mem_addr[13:0] : 14'h3FFF;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    int   sb[$];
    int   wr_total = 0, mem_total = 0, rd_total = 0, done_total = 0;
    int   run = 0, exp_patch = 0;
    int   first_words [PATCH];
    bit   prev_done = 1'b0, prev_wr = 1'b0;
    vec_t tbl [PATCH];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            run       = 0;
            exp_patch = 0;
            prev_done = 1'b0;
            prev_wr   = 1'b0;
        end else begin
            if (bus.mem_rd_en) mem_total++;
            if (bus.wr_en) begin
                wr_total++;
                if (exp_patch == 0 && run < PATCH) first_words[run] = int'(bus.data_in);
                run++;
                if (sb.size() == 0) check("wr_unexpected", 1, 0);
                else check("data_in", int'(bus.data_in), sb.pop_front());
            end else if (prev_wr) begin
                check("wr_burst_len", run, PATCH);
            end
            if (bus.rd_en) begin
                rd_total++;
                check("rd_after_writes", run, PATCH);
                check("out_row", int'(out_row), exp_patch / OUT_W);
                check("out_col", int'(out_col), exp_patch % OUT_W);
                exp_patch++;
                run = 0;
            end
            if (prev_done) begin
                check("busy_after_done", int'(busy), 0);
                check("done_width", int'(done), 0);
            end
            if (done) begin
                done_total++;
                check("busy_in_done", int'(busy), 1);
                exp_patch = 0;
            end
            prev_done = done;
            prev_wr   = bus.wr_en;
        end
    end

    // Push the expected FIFO stream for a full pass; returns the read count.
    task automatic push_pass(output int reads);
        int r, c, kr, kc, ch, ir, ic;
        reads = 0;
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < PATCH; s++) begin
                r  = p / OUT_W;
                c  = p % OUT_W;
                kr = s / (K * CH);
                kc = (s / CH) % K;
                ch = s % CH;
                ir = r * STRIDE + kr - PAD_EFF;
                ic = c * STRIDE + kc - PAD_EFF;
                if (ir >= 0 && ir < IMG_H && ic >= 0 && ic < IMG_W) begin
                    sb.push_back(((ir * IMG_W + ic) * CH + ch) & 32'h3FFF);
                    reads++;
                end else begin
                    sb.push_back(0);
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd_en"}, int'(bus.mem_rd_en), 0);
        check({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
        check({tag, "_wr_en"}, int'(bus.wr_en), 0);
        check({tag, "_data_in"}, int'(bus.data_in), 0);
        check({tag, "_rd_en"}, int'(bus.rd_en), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_out_row"}, int'(out_row), 0);
        check({tag, "_out_col"}, int'(out_col), 0);
    endtask

    // Wait (bounded) for rd_en, optionally stall in WAIT, then ack one cycle.
    task automatic ack_patch(input int stall, output int rd_cyc);
        bit seen;
        int wr0, mem0, rd0;
        seen   = 1'b0;
        rd_cyc = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.rd_en) begin
                seen   = 1'b1;
                rd_cyc = cyc;
            end
        end
        check("rd_en_seen", int'(seen), 1);
        @(posedge clk);
        #1;
        if (stall > 0) begin
            wr0  = wr_total;
            mem0 = mem_total;
            rd0  = rd_total;
            repeat (stall) @(posedge clk);
            #1;
            check("stall_wr_en", wr_total - wr0, 0);
            check("stall_mem_rd_en", mem_total - mem0, 0);
            check("stall_rd_en", rd_total - rd0, 0);
            check("stall_busy", int'(busy), 1);
        end
        bus.patch_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.patch_ack = 1'b0;
    endtask

    task automatic start_pass(output int t0, output int reads);
        push_pass(reads);
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic full_pass(input string tag, input bit extras);
        int  t0, rc, reads, wr0, mem0, rd0, dn0;
        bit  seen;
        wr0 = wr_total;
        mem0 = mem_total;
        rd0 = rd_total;
        dn0 = done_total;
        start_pass(t0, reads);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                seen = 1'b1;
                check({tag, "_first_wr_cyc"}, cyc, t0 + 2);
                check({tag, "_first_row"}, int'(out_row), 0);
                check({tag, "_first_col"}, int'(out_col), 0);
            end
        end
        check({tag, "_first_wr_seen"}, int'(seen), 1);
        for (int p = 0; p < NP; p++) begin
            if (extras && p == 2) ack_patch(50, rc);
            else if (extras && p == 3) ack_patch(5, rc);
            else ack_patch(0, rc);
            if (p == 0) begin
                check({tag, "_first_rd_cyc"}, rc, t0 + PATCH + 2);
                for (int i = 0; i < PATCH; i++)
                    check({tag, "_tbl_patch00"}, first_words[tbl[i].slot], tbl[i].exp_data);
            end
            if (extras && p == 0) begin
                start = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                start = 1'b0;
            end
            if (extras && p == 2) begin
                bus.patch_ack = 1'b1;
                @(posedge clk);
                #1;
                bus.patch_ack = 1'b0;
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        repeat (3) @(negedge clk);
        check({tag, "_rd_count"}, rd_total - rd0, NP);
        check({tag, "_wr_count"}, wr_total - wr0, NP * PATCH);
        check({tag, "_mem_count"}, mem_total - mem0, reads);
        check({tag, "_done_count"}, done_total - dn0, 1);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_idle_busy"}, int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t0, reads, rc, rd0;
        foreach (segs[i]) begin
            for (int j = 0; j < segs[i].len; j++) begin
                tbl[segs[i].first + j].slot     = segs[i].first + j;
                tbl[segs[i].first + j].exp_data = (segs[i].pad != 0) ? 0 : segs[i].base + j;
            end
        end
        bus.patch_ack = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full pass with start re-asserted while busy, a long WAIT stall and
        // an ack pulse during LOAD.
        full_pass("pass1", 1'b1);

        // Abort mid-LOAD of patch 5, slot 10.
        start_pass(t0, reads);
        for (int p = 0; p < 5; p++) ack_patch(0, rc);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        rd0 = rd_total;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_rd_en", rd_total - rd0, 0);
        check("abort_idle_busy", int'(busy), 0);

        // Fresh pass after the abort restarts at (0,0), slot 0.
        full_pass("pass3", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
